cpsr_bank: RTL and testbench
============================

# cpsr_bank

Parametrised program-status register with banked saved copies (SPSRs), the successor to the single fixed 32-bit CPSR. It holds the condition flags with per-flag write enables, a mode field and an interrupt-mask bit. A small FSM sequences exception entry (CPSR saved into the target mode's SPSR, then the mode switches) and exception return (CPSR restored from the current SPSR). It sits beside the execute stage, feeding flags to condition evaluation and mode to the register file.

## Interface
- WIDTH, 32: status register width.
- FLAGSW, 4: number of condition flags (N,Z,C,V from MSB down).
- FLAGS_START, 28: bit index of the lowest flag; flags occupy [FLAGS_START+FLAGSW-1:FLAGS_START].
- MODEW, 2: mode field width; mode occupies [MODEW-1:0].
- IMASK_BIT, 7: interrupt-mask bit index.
- NBANK, 2: number of SPSR banks; legal modes are 0 (user, no SPSR) through NBANK; NBANK ≤ 2^MODEW-1.
- RESET_MODE, 1: mode loaded at reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- should_set_cpsr  in  FLAGSW  per-flag write enable.
- cpsrwd  in  FLAGSW  new flag values.
- exc_req  in  1  exception entry request (level, held until exc_ack).
- exc_mode  in  MODEW  target mode of the exception.
- eret_req  in  1  exception return request (level, held until eret_ack).
- exc_ack  out  1  one-cycle pulse: entry complete.
- eret_ack  out  1  one-cycle pulse: return complete.
- err  out  1  one-cycle pulse: illegal request (eret in mode 0).
- busy  out  1  high in ENTER/RETURN; flag writes ignored.
- out  out  WIDTH  current CPSR (registered).
- spsr_out  out  WIDTH  SPSR of current mode; all-zero in mode 0.
- flags_fwd  out  FLAGSW  bypassed next flag value (combinational merge of should_set_cpsr/cpsrwd over current flags; equals current flags while busy).

## Operation
- States: IDLE, ENTER, RETURN. Reset → IDLE.
- Reset: out = 0 except mode = RESET_MODE and IMASK_BIT = 1; all SPSRs = 0; exc_ack, eret_ack, err, busy = 0.
- Flag write (IDLE only): for each i, flag i ← cpsrwd[i] if should_set_cpsr[i], else held. All bits outside flags are held. In ENTER/RETURN, should_set_cpsr is ignored entirely.
- IDLE, exc_req=1 with exc_mode in 1..NBANK:
  - Edge: SPSR[exc_mode-1] ← CPSR with that cycle's flag write merged in; the flag write also lands in CPSR; target latched; → ENTER.
  - exc_mode = 0 or > NBANK: request ignored, no ack, stays IDLE.
- ENTER (one cycle): exc_ack=1, busy=1. Edge: mode ← target, IMASK_BIT ← 1, flags and other bits unchanged; → IDLE.
- IDLE, eret_req=1 (exc_req=0): that cycle's flag write applies; → RETURN.
- RETURN (one cycle): busy=1. Mode ≠ 0: eret_ack=1, edge CPSR ← SPSR[mode-1] (all WIDTH bits). Mode = 0: err=1, eret_ack=1, CPSR unchanged. → IDLE.
- exc_req and eret_req both high in IDLE: exc_req wins; eret_req stays pending.
- Requests are sampled only in IDLE. Requesters deassert in the ack cycle; the FSM is back in IDLE the following cycle.
- Nested entry into the current mode overwrites that mode's SPSR (no stacking).
- rst asserted in any state: all state returns to reset values next edge; an in-flight request is abandoned with no ack.

## Timing
- Flag write accepted in cycle T → visible on out at T+1; flags_fwd shows it in T.
- Exception entry: accept T, ENTER T+1 (exc_ack), new mode on out at T+2; SPSR visible on spsr_out from T+2 (new mode selects it).
- Return: accept T, RETURN T+1 (eret_ack), restored CPSR on out at T+2.
- Throughput: one entry or return per 2 cycles; flag writes blocked for exactly 1 cycle per operation.

## Test plan
- Reset, then should_set_cpsr=4'b1010, cpsrwd=4'b1111 → out[31:28]=4'b1010, mode=1, out[7]=1 next cycle; other bits unchanged.
- Mode 0, flags 4'b0101; exc_req, exc_mode=2, same-cycle write N=1 → SPSR[1][31:28]=4'b1101, out mode=2, out[7]=1 at T+2; exc_ack pulse at T+1 only.
- Then eret_req → out equals saved SPSR (mode 0, flags 4'b1101) at T+2; eret_ack at T+1; should_set_cpsr in T+1 has no effect.
- exc_req and eret_req together in IDLE → entry first; eret completes after exc_ack; exc_mode=3 (NBANK=2) → no ack, no state change.
- eret_req in mode 0 → err and eret_ack pulse at T+1, out unchanged; rst asserted during ENTER → no exc_ack, out = reset value next cycle.

Source files
------------

// File: rtl/cpsr_bank_if.sv
// cpsr_bank bus: flag writes, exception entry/return handshake,
// and status outputs toward execute and regfile.
interface cpsr_bank_if #(
  parameter int WIDTH  = 32,
  parameter int FLAGSW = 4,
  parameter int MODEW  = 2
);
  logic [FLAGSW-1:0] should_set_cpsr;
  logic [FLAGSW-1:0] cpsrwd;
  logic              exc_req;
  logic [MODEW-1:0]  exc_mode;
  logic              eret_req;
  logic              exc_ack;
  logic              eret_ack;
  logic              err;
  logic              busy;
  logic [WIDTH-1:0]  out;
  logic [WIDTH-1:0]  spsr_out;
  logic [FLAGSW-1:0] flags_fwd;

  modport master (
    output should_set_cpsr, cpsrwd,
    output exc_req, exc_mode, eret_req,
    input  exc_ack, eret_ack, err, busy,
    input  out, spsr_out, flags_fwd
  );

  modport slave (
    input  should_set_cpsr, cpsrwd,
    input  exc_req, exc_mode, eret_req,
    output exc_ack, eret_ack, err, busy,
    output out, spsr_out, flags_fwd
  );
endinterface

// File: rtl/cpsr_bank.sv
// Program-status register with banked SPSRs and a small
// FSM sequencing exception entry and return.
module cpsr_bank #(
  parameter int WIDTH       = 32,
  parameter int FLAGSW      = 4,
  parameter int FLAGS_START = 28,
  parameter int MODEW       = 2,
  parameter int IMASK_BIT   = 7,
  parameter int NBANK       = 2,
  parameter int RESET_MODE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  cpsr_bank_if.slave  bus
);
  localparam int FHI = FLAGS_START + FLAGSW - 1;
  localparam logic [MODEW-1:0] NB = MODEW'(NBANK);
  localparam logic [WIDTH-1:0] RST_CPSR =
    (WIDTH'(1) << IMASK_BIT) | WIDTH'(RESET_MODE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTER,
    S_RETURN
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cpsr_q, cpsr_d;
  logic [WIDTH-1:0]  spsr_q [NBANK];
  logic [WIDTH-1:0]  spsr_d [NBANK];
  logic [MODEW-1:0]  tgt_q, tgt_d;

  logic [FLAGSW-1:0] cur_flags;
  logic [FLAGSW-1:0] merged;
  logic [MODEW-1:0]  cur_mode;
  logic [WIDTH-1:0]  cpsr_wr;
  logic [WIDTH-1:0]  spsr_sel;
  logic              exc_ok;

  assign cur_flags = cpsr_q[FHI:FLAGS_START];
  assign cur_mode  = cpsr_q[MODEW-1:0];
  assign merged    = (cur_flags & ~bus.should_set_cpsr)
                   | (bus.cpsrwd & bus.should_set_cpsr);
  assign exc_ok    = bus.exc_req
                   && (bus.exc_mode != '0)
                   && (bus.exc_mode <= NB);

  // CPSR with this cycle's flag write merged in
  always_comb begin
    cpsr_wr = cpsr_q;
    cpsr_wr[FHI:FLAGS_START] = merged;
  end

  // SPSR of the current mode; user mode has none
  always_comb begin
    spsr_sel = '0;
    for (int b = 0; b < NBANK; b++)
      if (cur_mode == MODEW'(b + 1))
        spsr_sel = spsr_q[b];
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state: entry beats return when both pending
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (exc_ok)            state_d = S_ENTER;
        else if (bus.eret_req) state_d = S_RETURN;
      end
      S_ENTER:  state_d = S_IDLE;
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs; pulses suppressed while reset is applied
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.exc_ack   = (state_q == S_ENTER) && !rst;
    bus.eret_ack  = (state_q == S_RETURN) && !rst;
    bus.err       = (state_q == S_RETURN) && !rst
                  && (cur_mode == '0);
    bus.out       = cpsr_q;
    bus.spsr_out  = spsr_sel;
    bus.flags_fwd = (state_q == S_IDLE) ? merged
                                        : cur_flags;
  end

  // datapath next values for CPSR, SPSR banks and target
  always_comb begin
    cpsr_d = cpsr_q;
    spsr_d = spsr_q;
    tgt_d  = tgt_q;
    unique case (state_q)
      S_IDLE: begin
        cpsr_d = cpsr_wr;
        if (exc_ok) begin
          tgt_d = bus.exc_mode;
          for (int b = 0; b < NBANK; b++)
            if (bus.exc_mode == MODEW'(b + 1))
              spsr_d[b] = cpsr_wr;
        end
      end
      S_ENTER: begin
        cpsr_d[MODEW-1:0] = tgt_q;
        cpsr_d[IMASK_BIT] = 1'b1;
      end
      S_RETURN: begin
        if (cur_mode != '0) cpsr_d = spsr_sel;
      end
      default: cpsr_d = cpsr_q;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cpsr_q <= RST_CPSR;
      tgt_q  <= '0;
      for (int b = 0; b < NBANK; b++)
        spsr_q[b] <= '0;
    end else begin
      cpsr_q <= cpsr_d;
      tgt_q  <= tgt_d;
      for (int b = 0; b < NBANK; b++)
        spsr_q[b] <= spsr_d[b];
    end
  end
endmodule

// File: tb/tb_cpsr_bank.sv
// Scoreboard bench for cpsr_bank: expectations are queued
// with a due cycle and compared on the falling edge.
module tb_cpsr_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpsr_bank_if #(.WIDTH(32), .FLAGSW(4), .MODEW(2)) bus_if ();

  cpsr_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef enum {
    S_OUT, S_SPSR, S_FWD, S_EACK, S_RACK, S_ERR, S_BUSY
  } sig_e;

  typedef struct {
    int          due;
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_OUT:   return bus_if.out;
      S_SPSR:  return bus_if.spsr_out;
      S_FWD:   return 32'(bus_if.flags_fwd);
      S_EACK:  return 32'(bus_if.exc_ack);
      S_RACK:  return 32'(bus_if.eret_ack);
      S_ERR:   return 32'(bus_if.err);
      default: return 32'(bus_if.busy);
    endcase
  endfunction

  task automatic exp_at(input int d, input string tag,
                        input sig_e s, input logic [31:0] e);
    exp_t it;
    it.due = cyc + d;
    it.tag = tag;
    it.sig = s;
    it.exp = e;
    sb.push_back(it);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, observe(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus_if.should_set_cpsr = '0;
    bus_if.cpsrwd          = '0;
    bus_if.exc_req         = 1'b0;
    bus_if.exc_mode        = '0;
    bus_if.eret_req        = 1'b0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    exp_at(0, "rst_out", S_OUT, 32'h0000_0081);
    exp_at(0, "rst_spsr", S_SPSR, 32'h0);
    exp_at(0, "rst_busy", S_BUSY, 32'h0);
    exp_at(0, "rst_eack", S_EACK, 32'h0);
    step();

    bus_if.should_set_cpsr = 4'b1010;
    bus_if.cpsrwd          = 4'b1111;
    exp_at(0, "fw_fwd", S_FWD, 32'hA);
    exp_at(1, "fw_out", S_OUT, 32'hA000_0081);
    step();
    idle_in();
    step();

    bus_if.eret_req = 1'b1;
    exp_at(1, "r0_ack", S_RACK, 32'h1);
    exp_at(1, "r0_err", S_ERR, 32'h0);
    exp_at(1, "r0_busy", S_BUSY, 32'h1);
    exp_at(1, "r0_fwd", S_FWD, 32'hA);
    exp_at(2, "r0_out", S_OUT, 32'h0);
    exp_at(2, "r0_ack2", S_RACK, 32'h0);
    step();
    bus_if.eret_req        = 1'b0;
    bus_if.should_set_cpsr = 4'b1111;
    bus_if.cpsrwd          = 4'b1111;
    step();
    idle_in();

    bus_if.should_set_cpsr = 4'b1111;
    bus_if.cpsrwd          = 4'b0101;
    exp_at(1, "f5_out", S_OUT, 32'h5000_0000);
    step();
    idle_in();

    bus_if.exc_req         = 1'b1;
    bus_if.exc_mode        = 2'd2;
    bus_if.should_set_cpsr = 4'b1000;
    bus_if.cpsrwd          = 4'b1000;
    exp_at(0, "en_ack0", S_EACK, 32'h0);
    exp_at(1, "en_ack1", S_EACK, 32'h1);
    exp_at(1, "en_busy", S_BUSY, 32'h1);
    exp_at(1, "en_out1", S_OUT, 32'hD000_0000);
    exp_at(2, "en_ack2", S_EACK, 32'h0);
    exp_at(2, "en_out2", S_OUT, 32'hD000_0082);
    exp_at(2, "en_spsr", S_SPSR, 32'hD000_0000);
    step();
    idle_in();
    step();

    bus_if.eret_req = 1'b1;
    exp_at(1, "er_ack", S_RACK, 32'h1);
    exp_at(1, "er_err", S_ERR, 32'h0);
    exp_at(2, "er_out", S_OUT, 32'hD000_0000);
    exp_at(2, "er_spsr", S_SPSR, 32'h0);
    step();
    bus_if.eret_req        = 1'b0;
    bus_if.should_set_cpsr = 4'b1111;
    bus_if.cpsrwd          = 4'b0000;
    step();
    idle_in();

    bus_if.exc_req  = 1'b1;
    bus_if.exc_mode = 2'd1;
    bus_if.eret_req = 1'b1;
    exp_at(1, "bo_eack", S_EACK, 32'h1);
    exp_at(1, "bo_rack", S_RACK, 32'h0);
    exp_at(2, "bo_out", S_OUT, 32'hD000_0081);
    exp_at(2, "bo_spsr", S_SPSR, 32'hD000_0000);
    exp_at(3, "bo_rack3", S_RACK, 32'h1);
    exp_at(3, "bo_eack3", S_EACK, 32'h0);
    exp_at(4, "bo_out4", S_OUT, 32'hD000_0000);
    step();
    bus_if.exc_req = 1'b0;
    step();
    step();
    bus_if.eret_req = 1'b0;
    step();

    bus_if.exc_req  = 1'b1;
    bus_if.exc_mode = 2'd3;
    exp_at(1, "bad_eack", S_EACK, 32'h0);
    exp_at(1, "bad_busy", S_BUSY, 32'h0);
    exp_at(2, "bad_eack2", S_EACK, 32'h0);
    exp_at(2, "bad_out", S_OUT, 32'hD000_0000);
    step();
    step();
    idle_in();

    bus_if.eret_req = 1'b1;
    exp_at(1, "u_err", S_ERR, 32'h1);
    exp_at(1, "u_rack", S_RACK, 32'h1);
    exp_at(2, "u_out", S_OUT, 32'hD000_0000);
    exp_at(2, "u_err2", S_ERR, 32'h0);
    step();
    idle_in();
    step();

    bus_if.exc_req  = 1'b1;
    bus_if.exc_mode = 2'd1;
    exp_at(1, "ra_eack", S_EACK, 32'h0);
    exp_at(2, "ra_out", S_OUT, 32'h0000_0081);
    exp_at(2, "ra_spsr", S_SPSR, 32'h0);
    exp_at(2, "ra_busy", S_BUSY, 32'h0);
    exp_at(2, "ra_eack2", S_EACK, 32'h0);
    step();
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
